uart_alu_sequencer: RTL and testbench

Frame controller between the UART receiver/transmitter and the combinational ALU. It collects a 3-byte command frame (operand A, operand B, opcode) and drives the ALU operands. It captures the result and transmits it with a proper tx handshake. An inter-byte timeout discards partial frames, and the block ignores traffic while a result is in flight.

---
 rtl/uart_alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// Frame controller between UART rx/tx and a combinational ALU: collects A, B, opcode,
// sends the result byte. Optional trailing checksum byte when UART_ALU_CHKSUM_EN is defined.
module uart_alu_sequencer #(
    parameter int DATA_W      = 8,
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rx_done_tick,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_tx_done_tick,
    input  logic [DATA_W-1:0] i_alu_res,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        CALC,
        WAIT_TX
`ifdef UART_ALU_CHKSUM_EN
        ,
        SEND_CHK,
        WAIT_CHK
`endif
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_busy;
    logic              r_frame_err;

    wire w_timeout = (r_cnt == CNT_LAST);

`ifdef UART_ALU_CHKSUM_EN
    function automatic logic [DATA_W-1:0] f_chksum(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [OP_W-1:0]   op,
                                                    input logic [DATA_W-1:0] res);
        return a ^ b ^ DATA_W'(op) ^ res;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (i_rx_done_tick) begin
                        r_alu_a <= i_rx_data;
                        r_state <= GET_B;
                    end
                end
                GET_B: begin
                    // An arriving byte beats the timeout on the same cycle.
                    if (i_rx_done_tick) begin
                        r_alu_b <= i_rx_data;
                        r_cnt   <= '0;
                        r_state <= GET_OP;
                    end else if (w_timeout) begin
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GET_OP: begin
                    if (i_rx_done_tick) begin
                        r_alu_op <= i_rx_data[OP_W-1:0];
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end else if (w_timeout) begin
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CALC: begin
                    r_tx_data  <= i_alu_res;
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done_tick) begin
`ifdef UART_ALU_CHKSUM_EN
                        r_state <= SEND_CHK;
`else
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef UART_ALU_CHKSUM_EN
                SEND_CHK: begin
                    // r_tx_data still holds the result byte just sent.
                    r_tx_data  <= f_chksum(r_alu_a, r_alu_b, r_alu_op, r_tx_data);
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_CHK;
                end
                WAIT_CHK: begin
                    if (i_tx_done_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed scenarios plus randomized frames
// checked against a byte-level ALU/checksum model.
module tb_uart_alu_sequencer;

    localparam int DATA_W = 8;
    localparam int OP_W   = 6;
    localparam int TMO    = 16;
`ifdef UART_ALU_CHKSUM_EN
    localparam int EXP_P = 2;
`else
    localparam int EXP_P = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_done_tick = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              tx_done_tick = 1'b0;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] alu_a, alu_b, tx_data;
    logic [OP_W-1:0]   alu_op;
    logic              tx_start, busy, frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0;

    uart_alu_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_rx_done_tick(rx_done_tick), .i_rx_data(rx_data),
        .i_tx_done_tick(tx_done_tick), .i_alu_res(alu_res),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_busy(busy), .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] chk_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [7:0] op6;
        op6 = op & 8'h3F;
        return a ^ b ^ op6 ^ alu_f(a, b, op6[5:0]);
    endfunction

    always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1 rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
    endtask

    // Drives a frame and records what the DUT transmitted; callers do the comparing.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int gap, input int dly, input bit only_op, input bit inject,
                             output int lat0, output int lat1, output int npulse,
                             output logic [7:0] b0, output logic [7:0] b1,
                             output bit stable, output bit busy_hi, output logic busy_end);
        lat0 = -1; lat1 = -1; npulse = 0; b0 = '0; b1 = '0; stable = 1'b1; busy_hi = 1'b1;
        if (!only_op) begin
            send_byte(a); idle(gap); send_byte(b); idle(gap);
        end
        send_byte(op);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_hi = 1'b0;
            if (tx_start === 1'b1) begin
                npulse++;
                if (lat0 < 0) begin lat0 = i; b0 = tx_data; end
            end
        end
        for (int j = 0; j < dly; j++) begin
            if (inject && j == 0) begin rx_data = 8'hFF; rx_done_tick = 1'b1; end
            @(negedge clk);
            rx_done_tick = 1'b0;
            if (tx_data !== b0) stable = 1'b0;
            if (tx_start === 1'b1) npulse++;
            if (busy !== 1'b1) busy_hi = 1'b0;
        end
        pulse_tx_done();
`ifdef UART_ALU_CHKSUM_EN
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_hi = 1'b0;
            if (tx_start === 1'b1) begin
                npulse++;
                if (lat1 < 0) begin lat1 = i; b1 = tx_data; end
            end
        end
        for (int j = 0; j < dly; j++) begin
            @(negedge clk);
            if (tx_data !== b1) stable = 1'b0;
            if (tx_start === 1'b1) npulse++;
        end
        pulse_tx_done();
`endif
        @(negedge clk);
        busy_end = busy;
    endtask

    task automatic count_ferr(input int n, output int cnt, output int at);
        cnt = 0; at = -1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin cnt++; at = i; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        n_checks++; if (alu_a !== 8'h00) begin n_errors++; $display("FAIL reset_alu_a: got %h expected 00", alu_a); end
        n_checks++; if (alu_b !== 8'h00) begin n_errors++; $display("FAIL reset_alu_b: got %h expected 00", alu_b); end
        n_checks++; if (alu_op !== 6'h00) begin n_errors++; $display("FAIL reset_alu_op: got %h expected 00", alu_op); end
        n_checks++; if ({tx_start, busy, frame_err} !== 3'b000) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 000", {tx_start, busy, frame_err}); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        int l0, l1, np; logic [7:0] b0, b1; bit st, bh; logic be;
        run_frame(8'h05, 8'h03, 8'h20, 2, 4, 1'b0, 1'b0, l0, l1, np, b0, b1, st, bh, be);
        n_checks++; if (l0 != 2) begin n_errors++; $display("FAIL basic_latency: got %0d expected 2", l0); end
        n_checks++; if (b0 !== 8'h08) begin n_errors++; $display("FAIL basic_result: got %h expected 08", b0); end
        n_checks++; if (np != EXP_P) begin n_errors++; $display("FAIL basic_pulses: got %0d expected %0d", np, EXP_P); end
        n_checks++; if (!st || !bh) begin n_errors++; $display("FAIL basic_hold_busy: got stable=%0d busy=%0d expected 1 1", st, bh); end
        n_checks++; if (be !== 1'b0) begin n_errors++; $display("FAIL basic_busy_end: got %b expected 0", be); end
`ifdef UART_ALU_CHKSUM_EN
        n_checks++; if (b1 !== 8'h2E || l1 != 2) begin n_errors++; $display("FAIL basic_chksum: got %h lat %0d expected 2e lat 2", b1, l1); end
`endif
    endtask

    task automatic test_timeout();
        int c, at, l0, l1, np; logic [7:0] b0, b1; bit st, bh; logic be;
        send_byte(8'h11);
        count_ferr(TMO + 4, c, at);
        n_checks++; if (c != 1 || at != TMO) begin n_errors++; $display("FAIL timeout_getb: got %0d pulses at %0d expected 1 at %0d", c, at, TMO); end
        n_checks++; if (alu_a !== 8'h11 || busy !== 1'b0) begin n_errors++; $display("FAIL timeout_hold: got a=%h busy=%b expected 11 0", alu_a, busy); end
        send_byte(8'h33); send_byte(8'h44);
        count_ferr(TMO + 4, c, at);
        n_checks++; if (c != 1 || at != TMO) begin n_errors++; $display("FAIL timeout_getop: got %0d pulses at %0d expected 1 at %0d", c, at, TMO); end
        n_checks++; if (alu_b !== 8'h44) begin n_errors++; $display("FAIL timeout_hold_b: got %h expected 44", alu_b); end
        run_frame(8'h02, 8'h03, 8'h20, 0, 3, 1'b0, 1'b0, l0, l1, np, b0, b1, st, bh, be);
        n_checks++; if (b0 !== 8'h05 || l0 != 2 || np != EXP_P) begin n_errors++; $display("FAIL timeout_recover: got %h lat %0d pulses %0d expected 05 2 %0d", b0, l0, np, EXP_P); end
    endtask

    task automatic test_boundary();
        int f0, l0, l1, np; logic [7:0] b0, b1; bit st, bh; logic be;
        f0 = ferr_cnt;
        send_byte(8'h11); idle(TMO - 1); send_byte(8'h22);
        n_checks++; if (alu_b !== 8'h22) begin n_errors++; $display("FAIL boundary_accept: got %h expected 22", alu_b); end
        run_frame(8'h00, 8'h00, 8'h20, 0, 2, 1'b1, 1'b0, l0, l1, np, b0, b1, st, bh, be);
        n_checks++; if (b0 !== 8'h33 || l0 != 2) begin n_errors++; $display("FAIL boundary_getop: got %h lat %0d expected 33 2", b0, l0); end
        n_checks++; if (ferr_cnt != f0) begin n_errors++; $display("FAIL boundary_no_err: got %0d errors expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_drop();
        int l0, l1, np; logic [7:0] b0, b1; bit st, bh; logic be;
        run_frame(8'h40, 8'h01, 8'h26, 1, 5, 1'b0, 1'b1, l0, l1, np, b0, b1, st, bh, be);
        n_checks++; if (alu_a !== 8'h40 || b0 !== 8'h41 || np != EXP_P) begin n_errors++; $display("FAIL drop_inflight: got a=%h res=%h pulses %0d expected 40 41 %0d", alu_a, b0, np, EXP_P); end
        run_frame(8'h0A, 8'h01, 8'h22, 0, 2, 1'b0, 1'b0, l0, l1, np, b0, b1, st, bh, be);
        n_checks++; if (b0 !== 8'h09 || alu_a !== 8'h0A) begin n_errors++; $display("FAIL drop_next: got res=%h a=%h expected 09 0a", b0, alu_a); end
    endtask

    task automatic test_reset_mid();
        int np;
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || tx_data !== 8'h08) begin n_errors++; $display("FAIL midrst_pre: got busy=%b data=%h expected 1 08", busy, tx_data); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err} !== '0) begin
            n_errors++; $display("FAIL midrst_outputs: got %h %h %h %h %b%b%b expected all 0", alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err);
        end
        pulse_tx_done();
        np = 0;
        repeat (6) begin @(negedge clk); if (tx_start === 1'b1 || busy === 1'b1) np++; end
        n_checks++; if (np != 0) begin n_errors++; $display("FAIL midrst_late_done: got %0d active cycles expected 0", np); end
    endtask

    task automatic test_random();
        logic [7:0] ops [7];
        logic [7:0] a, b, op, hi, e0, e1;
        int l0, l1, np, f0; logic [7:0] b0, b1; bit st, bh; logic be;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h00};
        f0 = ferr_cnt;
        for (int k = 0; k < 16; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            op = ops[$urandom_range(0, 6)];
            if (op == 8'h00) op = 8'($urandom);
            hi = 8'($urandom_range(0, 3));
            op = op | (hi << 6);
            e0 = alu_f(a, b, 6'(op & 8'h3F));
            e1 = chk_f(a, b, op);
            run_frame(a, b, op, $urandom_range(0, TMO - 1), $urandom_range(1, 8), 1'b0, 1'b0,
                      l0, l1, np, b0, b1, st, bh, be);
            n_checks++; if (b0 !== e0 || l0 != 2) begin n_errors++; $display("FAIL rand_result[%0d]: got %h lat %0d expected %h lat 2", k, b0, l0, e0); end
            n_checks++; if (np != EXP_P || !st || !bh || be !== 1'b0) begin
                n_errors++; $display("FAIL rand_handshake[%0d]: got pulses %0d stable %0d busy %0d end %b expected %0d 1 1 0", k, np, st, bh, be, EXP_P);
            end
`ifdef UART_ALU_CHKSUM_EN
            n_checks++; if (b1 !== e1 || l1 != 2) begin n_errors++; $display("FAIL rand_chksum[%0d]: got %h lat %0d expected %h lat 2", k, b1, l1, e1); end
`endif
        end
        n_checks++; if (ferr_cnt != f0) begin n_errors++; $display("FAIL rand_no_err: got %0d errors expected 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_boundary();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
